// File: rtl/turf_pkg.sv
// Shared widths, board geometry, colour codes and requester tags for the board RAM arbiter.
package turf_pkg;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DATA_W  = 3;
  localparam int unsigned Y_W     = 7;
  localparam int unsigned BOARD_W = 160;
  localparam int unsigned BOARD_H = 120;

  localparam logic [DATA_W-1:0] P1 = 3'b001;
  localparam logic [DATA_W-1:0] P2 = 3'b010;
  localparam logic [DATA_W-1:0] P3 = 3'b100;
  localparam logic [DATA_W-1:0] P4 = 3'b110;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_WR,
    REQ_DISP,
    REQ_SCAN
  } req_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the board RAM arbiter: painter write, display read, scanner read.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = turf_pkg::ADDR_W,
  parameter int unsigned DATA_W = turf_pkg::DATA_W
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;

  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_gnt;
  logic              scan_valid;
  logic [DATA_W-1:0] scan_data;

  modport master (
    output wr_req, wr_addr, wr_data, disp_req, disp_addr, scan_req, scan_addr,
    input  wr_gnt, disp_gnt, disp_valid, disp_data, scan_gnt, scan_valid, scan_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, disp_req, disp_addr, scan_req, scan_addr,
    output wr_gnt, disp_gnt, disp_valid, disp_data, scan_gnt, scan_valid, scan_data
  );
endinterface

// File: rtl/read_return_pipe.sv
// Two-stage read-return tracker: tag follows the RAM command, valid strobes line up with ram_q.
module read_return_pipe
  import turf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  req_e tag_in,
  output logic disp_valid,
  output logic scan_valid
);

  req_e tag_cmd;

  // Stage 1 tracks the cycle the command is on the RAM pins; stage 2 is the data cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_cmd    <= REQ_NONE;
      disp_valid <= 1'b0;
      scan_valid <= 1'b0;
    end else begin
      tag_cmd    <= (tag_in == REQ_DISP || tag_in == REQ_SCAN) ? tag_in : REQ_NONE;
      disp_valid <= (tag_cmd == REQ_DISP);
      scan_valid <= (tag_cmd == REQ_SCAN);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port board RAM arbiter: painter writes beat display reads, display beats scanner unless starved.
module ram_arbiter
  import turf_pkg::*;
#(
  parameter int unsigned ADDR_W       = turf_pkg::ADDR_W,
  parameter int unsigned DATA_W       = turf_pkg::DATA_W,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  ram_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              oob_err
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned X_W   = ADDR_W - Y_W;

  logic [CNT_W-1:0]  starve_cnt;
  logic              scan_pri;
  logic              wr_in_board;
  logic [X_W-1:0]    wr_x;
  logic [Y_W-1:0]    wr_y;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] disp_hold;
  logic [DATA_W-1:0] scan_hold;
  req_e              sel;

  assign scan_pri    = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign wr_x        = bus.wr_addr[ADDR_W-1:Y_W];
  assign wr_y        = bus.wr_addr[Y_W-1:0];
  assign wr_in_board = (wr_x < X_W'(BOARD_W)) && (wr_y < Y_W'(BOARD_H));

  // One winner per cycle; a starved scanner overtakes the display but never the painter.
  always_comb begin
    sel = REQ_NONE;
    if (!reset) begin
      if (bus.wr_req)                                        sel = REQ_WR;
      else if (bus.scan_req && (scan_pri || !bus.disp_req)) sel = REQ_SCAN;
      else if (bus.disp_req)                                 sel = REQ_DISP;
    end
  end

  assign bus.wr_gnt   = (sel == REQ_WR);
  assign bus.disp_gnt = (sel == REQ_DISP);
  assign bus.scan_gnt = (sel == REQ_SCAN);
  assign rd_addr      = (sel == REQ_SCAN) ? bus.scan_addr : bus.disp_addr;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ram_address <= '0;
      ram_wren    <= 1'b0;
      ram_data    <= '0;
      oob_err     <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      ram_wren <= 1'b0;
      if (sel == REQ_WR && wr_in_board) begin
        ram_address <= bus.wr_addr;
        ram_wren    <= 1'b1;
        ram_data    <= bus.wr_data;
      end else if (sel == REQ_DISP || sel == REQ_SCAN) begin
        ram_address <= rd_addr;
      end
      if (sel == REQ_WR && !wr_in_board) oob_err <= 1'b1;
      if (!bus.scan_req || sel == REQ_SCAN) starve_cnt <= '0;
      else if (!scan_pri)                   starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  read_return_pipe u_pipe (
    .clk        (CLOCK_50),
    .reset      (reset),
    .tag_in     (sel),
    .disp_valid (bus.disp_valid),
    .scan_valid (bus.scan_valid)
  );

  // Read data passes ram_q through on its valid cycle and otherwise holds the last return.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      disp_hold <= '0;
      scan_hold <= '0;
    end else begin
      if (bus.disp_valid) disp_hold <= ram_q;
      if (bus.scan_valid) scan_hold <= ram_q;
    end
  end

  assign bus.disp_data = bus.disp_valid ? ram_q : disp_hold;
  assign bus.scan_data = bus.scan_valid ? ram_q : scan_hold;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous board RAM.
module tb_ram_arbiter;
  import turf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] ram_address;
  logic        ram_wren;
  logic [2:0]  ram_data;
  logic [2:0]  ram_q;
  logic        oob_err;
  logic [2:0]  mem [0:32767];
  logic [2:0]  cols [4];
  int          errors = 0;
  int          checks = 0;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .bus         (bus),
    .ram_address (ram_address),
    .ram_wren    (ram_wren),
    .ram_data    (ram_data),
    .ram_q       (ram_q),
    .oob_err     (oob_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  function automatic logic [14:0] xy(input int x, input int y);
    return {8'(x), 7'(y)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.scan_req  = 1'b0;
    bus.scan_addr = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle();
    tick();
    tick();
    bus.wr_req = 1'b1; bus.disp_req = 1'b1; bus.scan_req = 1'b1;
    #1;
    checks++;
    if ({bus.wr_gnt, bus.disp_gnt, bus.scan_gnt} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt: got %b want 000", {bus.wr_gnt, bus.disp_gnt, bus.scan_gnt});
    end
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if ({ram_wren, oob_err, bus.disp_valid, bus.scan_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {ram_wren, oob_err, bus.disp_valid, bus.scan_valid});
    end
    checks++;
    if ({ram_address, ram_data, bus.disp_data, bus.scan_data} !== 24'd0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {ram_address, ram_data, bus.disp_data, bus.scan_data});
    end
  endtask

  task automatic test_write;
    bus.wr_req = 1'b1; bus.wr_addr = xy(20, 30); bus.wr_data = P2;
    #1;
    checks++;
    if ({bus.wr_gnt, bus.disp_gnt, bus.scan_gnt} !== 3'b100) begin
      errors++; $display("FAIL write_gnt: got %b want 100", {bus.wr_gnt, bus.disp_gnt, bus.scan_gnt});
    end
    tick();
    idle();
    #1;
    checks++;
    if ({ram_wren, ram_address, ram_data} !== {1'b1, xy(20, 30), P2}) begin
      errors++; $display("FAIL write_cmd: got %b/%h/%b want 1/%h/%b", ram_wren, ram_address, ram_data, xy(20, 30), P2);
    end
    tick();
    checks++;
    if ({ram_wren, ram_address} !== {1'b0, xy(20, 30)}) begin
      errors++; $display("FAIL write_idle: got %b/%h want 0/%h", ram_wren, ram_address, xy(20, 30));
    end
    // Preload addresses 0..3 with back-to-back writes.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.wr_req = 1'b1; bus.wr_addr = xy(0, i); bus.wr_data = cols[i];
      end else begin
        idle();
      end
      #1;
      if (i < 4) begin
        checks++;
        if (bus.wr_gnt !== 1'b1) begin
          errors++; $display("FAIL preload_gnt[%0d]: got %b want 1", i, bus.wr_gnt);
        end
      end
      if (i > 0) begin
        checks++;
        if ({ram_wren, ram_address, ram_data} !== {1'b1, xy(0, i - 1), cols[i - 1]}) begin
          errors++; $display("FAIL preload_cmd[%0d]: got %b/%h/%b want 1/%h/%b", i, ram_wren, ram_address, ram_data, xy(0, i - 1), cols[i - 1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_oob;
    bus.wr_req = 1'b1; bus.wr_addr = xy(159, 119); bus.wr_data = P1;
    tick();
    idle();
    #1;
    checks++;
    if ({ram_wren, oob_err} !== 2'b10) begin
      errors++; $display("FAIL edge_write: got wren/oob %b%b want 10", ram_wren, oob_err);
    end
    tick();
    bus.wr_req = 1'b1; bus.wr_addr = xy(160, 5); bus.wr_data = P3;
    #1;
    checks++;
    if (bus.wr_gnt !== 1'b1) begin
      errors++; $display("FAIL oob_gnt: got %b want 1", bus.wr_gnt);
    end
    tick();
    idle();
    #1;
    checks++;
    if ({ram_wren, oob_err} !== 2'b01) begin
      errors++; $display("FAIL oob_write: got wren/oob %b%b want 01", ram_wren, oob_err);
    end
    repeat (5) tick();
    checks++;
    if (oob_err !== 1'b1) begin
      errors++; $display("FAIL oob_sticky: got %b want 1", oob_err);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        bus.scan_req = 1'b1; bus.scan_addr = xy(0, i);
      end else begin
        idle();
      end
      #1;
      checks++;
      if (bus.scan_gnt !== (i < 4)) begin
        errors++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, bus.scan_gnt, (i < 4));
      end
      checks++;
      if (i >= 2 && i < 6) begin
        if ({bus.scan_valid, bus.scan_data} !== {1'b1, cols[i - 2]}) begin
          errors++; $display("FAIL b2b_ret[%0d]: got %b/%b want 1/%b", i, bus.scan_valid, bus.scan_data, cols[i - 2]);
        end
      end else if (bus.scan_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_quiet[%0d]: got valid %b want 0", i, bus.scan_valid);
      end
      tick();
    end
    checks++;
    if ({bus.scan_data, bus.disp_valid, bus.disp_data} !== {P4, 1'b0, 3'b000}) begin
      errors++; $display("FAIL b2b_hold: got %b/%b/%b want %b/0/000", bus.scan_data, bus.disp_valid, bus.disp_data, P4);
    end
  endtask

  task automatic test_priority;
    bus.wr_req = 1'b1; bus.wr_addr = xy(1, 1); bus.wr_data = P4;
    bus.disp_req = 1'b1; bus.disp_addr = xy(0, 0);
    bus.scan_req = 1'b1; bus.scan_addr = xy(0, 1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({bus.wr_gnt, bus.disp_gnt, bus.scan_gnt} !== 3'b100) begin
        errors++; $display("FAIL prio_wr[%0d]: got %b want 100", i, {bus.wr_gnt, bus.disp_gnt, bus.scan_gnt});
      end
      tick();
    end
    bus.wr_req = 1'b0;
    #1;
    checks++;
    if ({bus.wr_gnt, bus.disp_gnt, bus.scan_gnt} !== 3'b010) begin
      errors++; $display("FAIL prio_disp: got %b want 010", {bus.wr_gnt, bus.disp_gnt, bus.scan_gnt});
    end
    tick();
    idle();
    repeat (3) tick();
    checks++;
    if ({bus.disp_valid, bus.disp_data} !== {1'b0, P1}) begin
      errors++; $display("FAIL prio_hold: got %b/%b want 0/%b", bus.disp_valid, bus.disp_data, P1);
    end
  endtask

  task automatic test_starve;
    logic exp_scan;
    bus.disp_req = 1'b1; bus.disp_addr = xy(0, 0);
    bus.scan_req = 1'b1; bus.scan_addr = xy(0, 1);
    for (int i = 0; i < 34; i++) begin
      exp_scan = (i == 16 || i == 33);
      #1;
      checks++;
      if ({bus.disp_gnt, bus.scan_gnt} !== {~exp_scan, exp_scan}) begin
        errors++; $display("FAIL starve[%0d]: got disp/scan %b%b want %b%b", i, bus.disp_gnt, bus.scan_gnt, ~exp_scan, exp_scan);
      end
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_raw;
    bus.wr_req = 1'b1; bus.wr_addr = xy(50, 60); bus.wr_data = P3;
    bus.disp_req = 1'b1; bus.disp_addr = xy(50, 60);
    #1;
    checks++;
    if ({bus.wr_gnt, bus.disp_gnt} !== 2'b10) begin
      errors++; $display("FAIL raw_first: got wr/disp %b want 10", {bus.wr_gnt, bus.disp_gnt});
    end
    tick();
    bus.wr_req = 1'b0;
    #1;
    checks++;
    if ({bus.disp_gnt, ram_wren} !== 2'b11) begin
      errors++; $display("FAIL raw_second: got disp_gnt/wren %b want 11", {bus.disp_gnt, ram_wren});
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.disp_valid !== 1'b0) begin
      errors++; $display("FAIL raw_early: got valid %b want 0", bus.disp_valid);
    end
    tick();
    checks++;
    if ({bus.disp_valid, bus.disp_data} !== {1'b1, P3}) begin
      errors++; $display("FAIL raw_ret: got %b/%b want 1/%b", bus.disp_valid, bus.disp_data, P3);
    end
    tick();
    checks++;
    if ({bus.disp_valid, bus.disp_data} !== {1'b0, P3}) begin
      errors++; $display("FAIL raw_hold: got %b/%b want 0/%b", bus.disp_valid, bus.disp_data, P3);
    end
  endtask

  task automatic test_reset_inflight;
    bus.disp_req = 1'b1; bus.disp_addr = xy(0, 2);
    #1;
    checks++;
    if (bus.disp_gnt !== 1'b1) begin
      errors++; $display("FAIL inflight_gnt: got %b want 1", bus.disp_gnt);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.wr_gnt, bus.disp_gnt, bus.scan_gnt} !== 3'b000) begin
      errors++; $display("FAIL inflight_rst_gnt: got %b want 000", {bus.wr_gnt, bus.disp_gnt, bus.scan_gnt});
    end
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if ({bus.disp_valid, bus.scan_valid, ram_wren, oob_err} !== 4'b0000) begin
      errors++; $display("FAIL inflight_flags: got %b want 0000", {bus.disp_valid, bus.scan_valid, ram_wren, oob_err});
    end
    checks++;
    if ({ram_address, ram_data, bus.disp_data, bus.scan_data} !== 24'd0) begin
      errors++; $display("FAIL inflight_data: got %h want 0", {ram_address, ram_data, bus.disp_data, bus.scan_data});
    end
    tick();
    checks++;
    if ({bus.disp_valid, bus.scan_valid} !== 2'b00) begin
      errors++; $display("FAIL inflight_late: got %b want 00", {bus.disp_valid, bus.scan_valid});
    end
  endtask

  initial begin
    cols[0] = P1; cols[1] = P2; cols[2] = P3; cols[3] = P4;
    test_reset();
    test_write();
    test_oob();
    test_back_to_back();
    test_priority();
    test_starve();
    test_raw();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, board RAM address width {x[7:0], y[6:0]}.
REQ-002 Parameter DATA_W, default 3, colour code width.
REQ-003 Parameter STARVE_LIMIT, default 16, maximum cycles the scanner waits while display is granted.
REQ-004 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 wr_req / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  painter write request, address and colour.
REQ-007 wr_gnt  out  1  painter request accepted this cycle.
REQ-008 disp_req / disp_addr  in  1 / ADDR_W  display read request and address.
REQ-009 disp_gnt, disp_valid  out  1, 1  display grant; display read-data valid.
REQ-010 disp_data  out  DATA_W  display read data.
REQ-011 scan_req / scan_addr  in  1 / ADDR_W  score-scanner read request and address.
REQ-012 scan_gnt, scan_valid  out  1, 1  scanner grant; scanner read-data valid.
REQ-013 scan_data  out  DATA_W  scanner read data.
REQ-014 ram_address / ram_wren / ram_data  out  ADDR_W / 1 / DATA_W  single-port board RAM command.
REQ-015 ram_q  in  DATA_W  RAM read data, valid one cycle after the command cycle.
REQ-016 oob_err  out  1  sticky: an out-of-board write was dropped.

Function
REQ-017 The block SHALL grant at most one requester per cycle; gnt outputs are combinational from the req inputs and internal state.
REQ-018 A requester SHALL hold req and its address/data stable until it sees gnt; gnt is a one-cycle acceptance.
REQ-019 Base priority SHALL be wr > disp > scan.
REQ-020 starve_cnt SHALL increment each cycle scan_req is high and scan is not granted, and clear on scan grant or when scan_req is low.
REQ-021 When starve_cnt == STARVE_LIMIT, scan SHALL take priority over disp; wr still wins.
REQ-022 starve_cnt SHALL saturate at STARVE_LIMIT.
REQ-023 On grant in cycle N, ram_address/ram_wren/ram_data SHALL be registered and driven in cycle N+1.
REQ-024 ram_wren SHALL be 1 only in the cycle after a write grant; reads and idle cycles drive ram_wren 0 and leave ram_address unchanged when idle.
REQ-025 A write with x > 159 or y > 119 SHALL still be granted, but ram_wren stays 0 and oob_err sets.
REQ-026 For a read granted in cycle N, the matching *_valid SHALL pulse in cycle N+2 with *_data = ram_q of that cycle; read latency is fixed at 2.
REQ-027 Back-to-back read grants SHALL produce back-to-back valids in grant order, with no reordering or loss.
REQ-028 When no read is returning, disp_data and scan_data SHALL hold their previous value.
REQ-029 Simultaneous wr and read to the same address in one cycle: the write is granted, and the read is granted on a later cycle and returns the new colour.

Reset
REQ-030 On reset all gnt, valid, ram_wren, oob_err and starve_cnt SHALL be 0.
REQ-031 On reset ram_address, ram_data, disp_data and scan_data SHALL be 0.
REQ-032 Reads in flight when reset asserts SHALL be discarded; no valid pulses after reset for pre-reset grants.
REQ-033 Grants SHALL be 0 during any cycle reset is high.

Structure
REQ-034 Shared package turf_pkg SHALL hold ADDR_W, DATA_W, BOARD_W=160, BOARD_H=120, colour codes P1=001, P2=010, P3=100, P4=110, and the requester enum {REQ_NONE, REQ_WR, REQ_DISP, REQ_SCAN}.
REQ-035 The 2-stage read-return pipeline (valid + requester tag) SHALL be a sub-module named read_return_pipe.

Verification
REQ-036 wr_req with addr {8'd20, 7'd30}, data 3'b010 -> wr_gnt same cycle; next cycle ram_wren=1, ram_address={20,30}, ram_data=010.
REQ-037 disp_req and scan_req held continuously -> scan granted on the cycle starve_cnt reaches 16; starve_cnt then clears; disp resumes.
REQ-038 wr_req, disp_req and scan_req all high -> wr_gnt only; disp is granted next cycle after wr_req drops.
REQ-039 wr_addr x=160, y=5 -> wr_gnt=1, ram_wren stays 0, oob_err=1 and it remains 1 until reset.
REQ-040 scan reads addr 0..3 back-to-back, RAM preloaded 001,010,100,110 -> scan_valid on 4 consecutive cycles, 2 cycles after each grant, data in order.
REQ-041 Reset asserted one cycle after a disp grant -> no disp_valid; all outputs 0 the cycle after reset.
